// File: rtl/tv_checker_if.sv
// tv_checker_if: bundles the test-vector load port, run control, the
// stimulus/response pair to the device under test, and the result status.
//   slave  : seen by tv_checker (drives ld_ready, dut_a and status).
//   master : seen by whoever loads the table and starts runs.
interface tv_checker_if #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 1,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             ld_valid;
  logic             ld_ready;
  logic [N_IN-1:0]  ld_in;
  logic [N_OUT-1:0] ld_exp;
  logic [N_OUT-1:0] ld_mask;
  logic             start;
  logic             clear;
  logic [N_IN-1:0]  dut_a;
  logic [N_OUT-1:0] dut_y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CW-1:0]    err_count;
  logic [IW-1:0]    first_fail;
  logic [CW-1:0]    n_loaded;

  modport slave (
    input  ld_valid, ld_in, ld_exp, ld_mask, start, clear, dut_y,
    output ld_ready, dut_a, busy, done, pass, err_count, first_fail, n_loaded
  );

  modport master (
    output ld_valid, ld_in, ld_exp, ld_mask, start, clear, dut_y,
    input  ld_ready, dut_a, busy, done, pass, err_count, first_fail, n_loaded
  );
endinterface

// File: rtl/tv_checker.sv
// tv_checker: holds a small table of {stimulus, expected, mask} vectors,
// plays them one by one onto dut_a, samples dut_y SETTLE cycles after each
// stimulus change and reports mismatch count and the first failing index.
//   clk, reset_n : single clock, asynchronous active-low reset
//   bus          : tv_checker_if.slave (load port, start/clear, dut_a/dut_y,
//                  busy/done/pass, err_count, first_fail, n_loaded)
module tv_checker #(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 1,
  parameter int DEPTH  = 8,
  parameter int SETTLE = 1
)(
  input  logic         clk,
  input  logic         reset_n,
  tv_checker_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [N_IN-1:0]  stim;
    logic [N_OUT-1:0] exp;
    logic [N_OUT-1:0] mask;
  } entry_t;

  state_t          state, state_nx;
  entry_t          tbl [DEPTH];
  logic [CW-1:0]   n_loaded;
  logic [IW-1:0]   idx, idx_nx;
  logic [SW-1:0]   cnt;
  logic [N_IN-1:0] dut_a;
  logic [CW-1:0]   err_count;
  logic [IW-1:0]   first_fail;

  logic ld_ready, ld_fire, go, sample, last, mismatch;

  assign ld_ready = (state == IDLE) && (n_loaded < CW'(DEPTH)) && !bus.start && !bus.clear;
  assign ld_fire  = bus.ld_valid && ld_ready;
  // start is honoured only outside RUN; clear overrides it
  assign go       = bus.start && !bus.clear && (state != RUN);
  // cnt counts cycles since dut_a last changed; sample on the SETTLE-th edge
  assign sample   = (state == RUN) && (cnt == SW'(SETTLE - 1));
  assign last     = (CW'(idx) == n_loaded - CW'(1));
  assign idx_nx   = idx + IW'(1);
  assign mismatch = |((bus.dut_y ^ tbl[idx].exp) & tbl[idx].mask);

  // Table storage: not reset, contents beyond n_loaded are simply stale
  always_ff @(posedge clk)
    if (ld_fire) tbl[n_loaded[IW-1:0]] <= {bus.ld_in, bus.ld_exp, bus.ld_mask};

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;

  always_comb begin
    state_nx = state;
    if (bus.clear) state_nx = IDLE;
    else begin
      case (state)
        IDLE, DONE: if (bus.start) state_nx = (n_loaded != '0) ? RUN : DONE;
        RUN:        if (sample && last) state_nx = DONE;
        default:    state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_loaded   <= '0;
      idx        <= '0;
      cnt        <= '0;
      dut_a      <= '0;
      err_count  <= '0;
      first_fail <= '0;
    end else if (bus.clear) begin
      n_loaded   <= '0;
      idx        <= '0;
      cnt        <= '0;
      dut_a      <= '0;
      err_count  <= '0;
      first_fail <= '0;
    end else begin
      if (ld_fire) n_loaded <= n_loaded + CW'(1);
      if (go) begin
        err_count  <= '0;
        first_fail <= '0;
        idx        <= '0;
        cnt        <= '0;
        // empty table goes straight to DONE with dut_a untouched
        if (n_loaded != '0) dut_a <= tbl[0].stim;
      end else if (sample) begin
        if (mismatch) begin
          err_count <= err_count + CW'(1);
          if (err_count == '0) first_fail <= idx;
        end
        if (!last) begin
          idx   <= idx_nx;
          dut_a <= tbl[idx_nx].stim;
          cnt   <= '0;
        end
      end else if (state == RUN) begin
        cnt <= cnt + SW'(1);
      end
    end
  end

  assign bus.ld_ready   = ld_ready;
  assign bus.dut_a      = dut_a;
  assign bus.busy       = (state == RUN);
  assign bus.done       = (state == DONE);
  assign bus.pass       = (state == DONE) && (err_count == '0);
  assign bus.err_count  = err_count;
  assign bus.first_fail = first_fail;
  assign bus.n_loaded   = n_loaded;
endmodule
